// File: rtl/cache_pkg.sv
// Shared types and constants for the cache fill controller slice.
package cache_pkg;

  localparam int unsigned DEF_WAYS       = 4;
  localparam int unsigned DEF_TOTAL_SIZE = 16;
  localparam int unsigned DEF_TIMEOUT    = 16;

  // Widths of way select and set index for the default geometry.
  localparam int unsigned WAY_W = $clog2(DEF_WAYS);
  localparam int unsigned IDX_W = $clog2(DEF_TOTAL_SIZE / DEF_WAYS);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_REQ,
    MEM_WAIT,
    FILL,
    DONE
  } fill_state_e;

  // Width helper that never returns zero, so single-entry geometries still
  // get a one-bit field.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way selection: lowest-numbered invalid way, otherwise the
// round-robin pointer of the set. Purely combinational.
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter  int unsigned WAYS = DEF_WAYS,
  localparam int unsigned WW   = clog2_min1(WAYS)
) (
  input  logic [WAYS-1:0] valid_in,
  input  logic [WW-1:0]   rr_ptr,
  output logic [WW-1:0]   victim,
  output logic            use_rr
);

  // Scan from the top way down so the lowest invalid way is the last to win.
  always_comb begin
    victim = rr_ptr;
    use_rr = 1'b1;
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (!valid_in[w-1]) begin
        victim = WW'(w - 1);
        use_rr = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache miss/refill controller: lookup, victim choice, memory refill
// handshake, array write and completion report, one request at a time.
// Optional feature macro: CACHE_FILL_TIMEOUT_EN (MEM_WAIT timeout with done_err).
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter  int unsigned WAYS       = DEF_WAYS,
  parameter  int unsigned TOTAL_SIZE = DEF_TOTAL_SIZE,
  parameter  int unsigned TIMEOUT    = DEF_TIMEOUT,
  localparam int unsigned SETS       = TOTAL_SIZE / WAYS,
  localparam int unsigned WW         = clog2_min1(WAYS),
  localparam int unsigned IW         = clog2_min1(SETS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [IW-1:0]   req_index,
  input  logic            hit,
  input  logic [WW-1:0]   hit_way,
  input  logic [WAYS-1:0] valid_in,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  output logic            arr_we,
  output logic [WW-1:0]   arr_way,
  output logic [IW-1:0]   arr_index,
  output logic            done_valid,
  output logic            done_hit,
  output logic [WW-1:0]   done_way,
  output logic            done_err
);

  if (WAYS < 2 || (WAYS & (WAYS - 1)) != 0 || TIMEOUT == 0) begin : g_bad_params
    $error("cache_fill_ctrl: WAYS must be a power of two >= 2 and TIMEOUT nonzero");
  end

  fill_state_e   state, state_n;
  logic [IW-1:0] idx_q;
  logic [WW-1:0] way_q;
  logic          hit_q;
  logic          use_rr_q;
  logic [WW-1:0] rr_ptr [SETS];
  logic [WW-1:0] sel_way;
  logic          sel_use_rr;
  logic          wait_expired;

  cache_victim_sel #(.WAYS(WAYS)) u_victim_sel (
    .valid_in (valid_in),
    .rr_ptr   (rr_ptr[idx_q]),
    .victim   (sel_way),
    .use_rr   (sel_use_rr)
  );

  // State register plus request index and lookup outcome capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      idx_q    <= '0;
      way_q    <= '0;
      hit_q    <= 1'b0;
      use_rr_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        idx_q <= req_index;
      end
      if (state == LOOKUP) begin
        hit_q    <= hit;
        way_q    <= hit ? hit_way : sel_way;
        use_rr_q <= !hit && sel_use_rr;
      end
    end
  end

  // Per-set round-robin pointers; advanced only once a pointer-chosen victim is written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        rr_ptr[s] <= '0;
      end
    end else if (state == FILL && use_rr_q) begin
      rr_ptr[idx_q] <= rr_ptr[idx_q] + 1'b1;
    end
  end

`ifdef CACHE_FILL_TIMEOUT_EN
  localparam int unsigned TW = clog2_min1(TIMEOUT);

  logic [TW-1:0] wait_cnt;
  logic          err_q;

  assign wait_expired = (wait_cnt == TW'(TIMEOUT - 1));

  // MEM_WAIT cycle counter and sticky error flag for the current request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == MEM_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (state == LOOKUP) begin
        err_q <= 1'b0;
      end else if (state == MEM_WAIT && !mem_resp_valid && wait_expired) begin
        err_q <= 1'b1;
      end
    end
  end

  assign done_err = (state == DONE) && err_q;
`else
  assign wait_expired = 1'b0;
  assign done_err     = 1'b0;
`endif

  // Next-state and Moore handshake/strobe outputs.
  always_comb begin
    state_n       = state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    arr_we        = 1'b0;
    done_valid    = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = LOOKUP;
      end
      LOOKUP: begin
        state_n = hit ? DONE : MEM_REQ;
      end
      MEM_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_n = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_resp_valid)    state_n = FILL;
        else if (wait_expired) state_n = DONE;
      end
      FILL: begin
        arr_we  = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // In IDLE the arrays see the incoming index so the tag read lines up with LOOKUP.
  assign arr_index = (state == IDLE) ? req_index : idx_q;
  assign arr_way   = way_q;
  assign done_hit  = (state == DONE) && hit_q;
  assign done_way  = (state == DONE) ? way_q : '0;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed self-checking bench for cache_fill_ctrl with a completion scoreboard.
module tb_cache_fill_ctrl;
  import cache_pkg::*;

  localparam int unsigned TO = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic [IDX_W-1:0]   req_index;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [DEF_WAYS-1:0] valid_in;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic               mem_resp_valid;
  logic               arr_we;
  logic [WAY_W-1:0]   arr_way;
  logic [IDX_W-1:0]   arr_index;
  logic               done_valid;
  logic               done_hit;
  logic [WAY_W-1:0]   done_way;
  logic               done_err;

  cache_fill_ctrl #(
    .WAYS       (DEF_WAYS),
    .TOTAL_SIZE (DEF_TOTAL_SIZE),
    .TIMEOUT    (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_index      (req_index),
    .hit            (hit),
    .hit_way        (hit_way),
    .valid_in       (valid_in),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .arr_we         (arr_we),
    .arr_way        (arr_way),
    .arr_index      (arr_index),
    .done_valid     (done_valid),
    .done_hit       (done_hit),
    .done_way       (done_way),
    .done_err       (done_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             hit;
    logic [WAY_W-1:0] way;
    logic             err;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   fills  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: array writes and completions are checked against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      fills = 0;
    end else begin
      if (arr_we) begin
        chk("fill_sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          chk("fill_on_miss_only", {sb[0].hit, sb[0].err}, 0);
          chk("fill_way", arr_way, sb[0].way);
          chk("fill_index", arr_index, sb[0].idx);
        end
        fills++;
      end
      if (done_valid) begin
        chk("done_sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("done_hit", done_hit, mon_e.hit);
          chk("done_way", done_way, mon_e.way);
          chk("done_err", done_err, mon_e.err);
          chk("fill_count", fills, (mon_e.hit || mon_e.err) ? 0 : 1);
        end
        fills = 0;
      end
    end
  end

  // One request: drives the lookup inputs and plays the memory side.
  task automatic txn(input logic [IDX_W-1:0] idx, input logic h, input logic [WAY_W-1:0] hw,
                     input logic [DEF_WAYS-1:0] vin, input logic [WAY_W-1:0] exp_way,
                     input int stall, input int rdel, input bit give_resp, input bit stray);
    int   cnt;
    int   exp_lat;
    bit   done;
    exp_t e;
    exp_lat = h ? 2 : (give_resp ? 5 + stall + rdel : 3 + stall + int'(TO));
    e.hit = h;
    e.way = h ? hw : exp_way;
    e.err = !h && !give_resp;
    e.idx = idx;
    sb.push_back(e);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_index = idx;
    hit       = h;
    hit_way   = hw;
    valid_in  = vin;
    @(negedge clk);
    req_valid = 1'b0;
    req_index = ~idx;
    cnt  = 1;
    done = 1'b0;
    while (!done && cnt < 200) begin
      if (done_valid) begin
        done = 1'b1;
        chk("latency", cnt, exp_lat);
      end else begin
        chk("arr_index_latched", arr_index, idx);
        if (cnt == 1) chk("mem_req_low_lookup", mem_req_valid, 0);
        if (!h && cnt >= 2 && cnt <= 2 + stall) chk("mem_req_valid_held", mem_req_valid, 1);
        mem_req_ready  = (cnt >= 2 + stall);
        mem_resp_valid = (give_resp && cnt == 3 + stall + rdel) || (stray && stall >= 2 && cnt == 3);
        @(negedge clk);
        cnt++;
      end
    end
    chk("done_seen", done, 1);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done_valid, 0);
    chk("back_to_idle", req_ready, 1);
  endtask

  initial begin
    rst            = 1'b0;
    req_valid      = 1'b0;
    req_index      = '0;
    hit            = 1'b0;
    hit_way        = '0;
    valid_in       = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_arr_we", arr_we, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_hit", done_hit, 0);
    chk("rst_done_err", done_err, 0);
    chk("rst_done_way", done_way, 0);
    rst = 1'b1;
    @(negedge clk);

    // Hit on set 2, way 3.
    txn(2'd2, 1'b1, 2'd3, 4'hF, 2'd0, 0, 0, 1'b1, 1'b0);
    // Cold miss on set 1 with way 2 invalid.
    txn(2'd1, 1'b0, 2'd0, 4'b1011, 2'd2, 0, 0, 1'b1, 1'b0);
    // Full set 0: round-robin victims 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      txn(2'd0, 1'b0, 2'd0, 4'hF, 2'(i % 4), 0, 0, 1'b1, 1'b0);
    end
    // Set 1 pointer untouched by set 0 traffic and by the invalid-way fill.
    txn(2'd1, 1'b0, 2'd0, 4'hF, 2'd0, 0, 0, 1'b1, 1'b0);
    txn(2'd1, 1'b0, 2'd0, 4'hF, 2'd1, 0, 0, 1'b1, 1'b0);
    // Backpressure on mem_req_ready with a stray response during MEM_REQ.
    txn(2'd3, 1'b0, 2'd0, 4'b0001, 2'd1, 5, 0, 1'b1, 1'b1);
    // A hit does not move the set 0 pointer (currently 1).
    txn(2'd0, 1'b1, 2'd2, 4'hF, 2'd0, 0, 0, 1'b1, 1'b0);
    txn(2'd0, 1'b0, 2'd0, 4'hF, 2'd1, 0, 0, 1'b1, 1'b0);

    // Reset while waiting for the refill response.
    req_valid = 1'b1;
    req_index = 2'd0;
    hit       = 1'b0;
    valid_in  = 4'hF;
    @(negedge clk);
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("abort_mem_req", mem_req_valid, 1);
    @(negedge clk);
    chk("abort_in_mem_wait", mem_req_valid, 0);
    mem_req_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_req_ready", req_ready, 1);
    chk("abort_mem_req_valid", mem_req_valid, 0);
    mem_resp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      chk("abort_no_arr_we", arr_we, 0);
      chk("abort_no_done", done_valid, 0);
      chk("abort_idle", req_ready, 1);
    end
    // Pointers back at 0 on both sets.
    txn(2'd0, 1'b0, 2'd0, 4'hF, 2'd0, 0, 0, 1'b1, 1'b0);
    txn(2'd1, 1'b0, 2'd0, 4'hF, 2'd0, 0, 0, 1'b1, 1'b0);

`ifdef CACHE_FILL_TIMEOUT_EN
    // No response: error completion, no fill, pointer stays put.
    txn(2'd2, 1'b0, 2'd0, 4'hF, 2'd0, 0, 0, 1'b0, 1'b0);
    txn(2'd2, 1'b0, 2'd0, 4'hF, 2'd0, 0, 0, 1'b1, 1'b0);
`else
    // A long refill wait still completes normally.
    txn(2'd2, 1'b0, 2'd0, 4'hF, 2'd0, 0, 20, 1'b1, 1'b0);
    txn(2'd2, 1'b0, 2'd0, 4'hF, 2'd1, 0, 0, 1'b1, 1'b0);
`endif

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
